// File: rtl/program_counter_stack_if.sv
// Control, W-bus input and status signals of the program counter with return-address stack.
// The tri-state W-bus driver stays a plain port on the module so the bus net can be resolved at its owner.
interface program_counter_stack_if #(
    parameter int ADDR_WIDTH  = 4,
    parameter int BUS_WIDTH   = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int SP_WIDTH = $clog2(STACK_DEPTH + 1);

    logic                  output_to_bus;
    logic                  increment;
    logic                  load;
    logic                  call;
    logic                  ret;
    logic [BUS_WIDTH-1:0]  w_bus_in;
    logic [ADDR_WIDTH-1:0] out;
    logic [SP_WIDTH-1:0]   sp;
    logic                  stack_full;
    logic                  stack_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output output_to_bus, increment, load, call, ret, w_bus_in,
        input  out, sp, stack_full, stack_empty, overflow, underflow
    );

    modport slave (
        input  output_to_bus, increment, load, call, ret, w_bus_in,
        output out, sp, stack_full, stack_empty, overflow, underflow
    );
endinterface

// File: rtl/program_counter_stack.sv
// Program counter with call/return stack; all state changes on the falling clock edge,
// one operation per edge with priority reset > ret > call > load > increment.
module program_counter_stack #(
    parameter int ADDR_WIDTH  = 4,
    parameter int BUS_WIDTH   = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    program_counter_stack_if.slave bus,
    output tri   [BUS_WIDTH-1:0] w_bus
);
    localparam int SP_WIDTH  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_WIDTH = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    generate
        if (ADDR_WIDTH > BUS_WIDTH) begin : g_bad_width
            $error("ADDR_WIDTH must not exceed BUS_WIDTH");
        end
        if (STACK_DEPTH < 1) begin : g_bad_depth
            $error("STACK_DEPTH must be at least 1");
        end
    endgenerate

    logic [ADDR_WIDTH-1:0] addr;
    logic [SP_WIDTH-1:0]   sp;
    logic                  overflow;
    logic                  underflow;
    logic [ADDR_WIDTH-1:0] stack [STACK_DEPTH];

    logic [ADDR_WIDTH-1:0] addr_next_seq;
    logic [ADDR_WIDTH-1:0] jump_target;
    logic [SP_WIDTH-1:0]   sp_dec;
    logic [IDX_WIDTH-1:0]  push_idx;
    logic [IDX_WIDTH-1:0]  pop_idx;
    logic                  full;
    logic                  empty;
    wire                   unused_bus_bits = ^bus.w_bus_in;

    assign addr_next_seq = addr + ADDR_WIDTH'(1);
    assign jump_target   = bus.w_bus_in[ADDR_WIDTH-1:0];
    assign sp_dec        = sp - SP_WIDTH'(1);
    assign push_idx      = IDX_WIDTH'(sp);
    assign pop_idx       = IDX_WIDTH'(sp_dec);
    assign full          = (sp == SP_WIDTH'(STACK_DEPTH));
    assign empty         = (sp == '0);

    always_ff @(negedge clock) begin
        if (reset) begin
            addr      <= '0;
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (bus.ret) begin
            if (!empty) begin
                addr <= stack[pop_idx];
                sp   <= sp_dec;
            end else begin
                underflow <= 1'b1;
            end
        end else if (bus.call) begin
            // A call on a full stack is refused outright: no push, no jump.
            if (!full) begin
                stack[push_idx] <= addr_next_seq;
                sp              <= sp + SP_WIDTH'(1);
                addr            <= jump_target;
            end else begin
                overflow <= 1'b1;
            end
        end else if (bus.load) begin
            addr <= jump_target;
        end else if (bus.increment) begin
            addr <= addr_next_seq;
        end
    end

    assign w_bus = bus.output_to_bus ? BUS_WIDTH'(addr) : {BUS_WIDTH{1'bz}};

    assign bus.out         = addr;
    assign bus.sp          = sp;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.overflow    = overflow;
    assign bus.underflow   = underflow;
endmodule
